// File: rtl/io_cell_pkg.sv
// Shared mode encodings and helpers for the SB_IO-style bidirectional pad cell.
package io_cell_pkg;

    localparam logic [3:0] OUT_NONE     = 4'b0000;
    localparam logic [3:0] OUT_COMB     = 4'b0110;
    localparam logic [3:0] OUT_REG      = 4'b0101;
    localparam logic [3:0] OUT_TRI_COMB = 4'b1010;
    localparam logic [3:0] OUT_TRI_REG  = 4'b1101;

    localparam logic [1:0] IN_REG_POS = 2'b00;
    localparam logic [1:0] IN_COMB    = 2'b01;
    localparam logic [1:0] IN_REG_NEG = 2'b10;

    function automatic logic [5:0] pin_type(input logic [3:0] out_mode, input logic [1:0] in_mode);
        return {out_mode, in_mode};
    endfunction

    function automatic logic out_mode_valid(input logic [3:0] out_mode);
        return out_mode inside {OUT_NONE, OUT_COMB, OUT_REG, OUT_TRI_COMB, OUT_TRI_REG};
    endfunction

endpackage

// File: rtl/io_bit_cell.sv
// One bit of the pad cell: tri-state output driver with optional output/enable
// registers, and a combinational, posedge- or negedge-registered input path.
module io_bit_cell
    import io_cell_pkg::*;
#(
    parameter logic [5:0] PIN_TYPE = 6'b101001,
    parameter logic       PULLUP   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    inout  wire  package_pin,
    input  logic output_enable,
    input  logic d_out_0,
    output logic d_in_0
);

    localparam logic [3:0] OUT_MODE = PIN_TYPE[5:2];
    localparam logic [1:0] IN_MODE  = PIN_TYPE[1:0];

    logic data_p1;
    logic en_p1;
    logic in_pos_p1;
    logic in_neg_p1;
    logic drive_en;
    logic drive_val;

    // Output stage: data and enable share one edge so a new enable never exposes stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p1   <= 1'b0;
            en_p1     <= 1'b0;
            in_pos_p1 <= 1'b0;
        end else begin
            data_p1   <= d_out_0;
            en_p1     <= output_enable;
            in_pos_p1 <= package_pin;
        end
    end

    // Falling-edge capture lines up with the DRAM clock edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            in_neg_p1 <= 1'b0;
        end else begin
            in_neg_p1 <= package_pin;
        end
    end

    always_comb begin
        drive_en  = 1'b0;
        drive_val = d_out_0;
        case (OUT_MODE)
            OUT_COMB:     drive_en = 1'b1;
            OUT_REG: begin
                drive_en  = 1'b1;
                drive_val = data_p1;
            end
            OUT_TRI_COMB: drive_en = output_enable;
            OUT_TRI_REG: begin
                drive_en  = en_p1;
                drive_val = data_p1;
            end
            default:      drive_en = 1'b0;
        endcase
    end

    assign package_pin = drive_en ? drive_val : 1'bz;

    always_comb begin
        d_in_0 = package_pin;
        case (IN_MODE)
            IN_REG_POS: d_in_0 = in_pos_p1;
            IN_REG_NEG: d_in_0 = in_neg_p1;
            default:    d_in_0 = package_pin;
        endcase
    end

    if (PULLUP) begin : g_pullup
        pullup pull_i (package_pin);
    end

    if (!out_mode_valid(OUT_MODE)) begin : g_bad_mode
        $warning("io_bit_cell: unsupported output mode %b, pad left undriven", OUT_MODE);
    end

endmodule

// File: rtl/bidir_io_cell.sv
// WIDTH-bit bidirectional pad: independent bit cells sharing clock, reset and output enable.
module bidir_io_cell
    import io_cell_pkg::*;
#(
    parameter int         WIDTH    = 8,
    parameter logic [5:0] PIN_TYPE = 6'b101001,
    parameter logic       PULLUP   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] package_pin,
    input  logic             output_enable,
    input  logic [WIDTH-1:0] d_out_0,
    output logic [WIDTH-1:0] d_in_0
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        io_bit_cell #(
            .PIN_TYPE (PIN_TYPE),
            .PULLUP   (PULLUP)
        ) bit_i (
            .clk           (clk),
            .rst           (rst),
            .package_pin   (package_pin[i]),
            .output_enable (output_enable),
            .d_out_0       (d_out_0[i]),
            .d_in_0        (d_in_0[i])
        );
    end

endmodule

// File: tb/tb_bidir_io_cell.sv
// Directed bench for bidir_io_cell: six parameterisations side by side on separate pads.
module tb_bidir_io_cell;

    logic       clk = 1'b0;
    logic       rst;
    logic       oe;
    logic [7:0] dout;
    logic       ext_en_def, ext_en_neg;
    logic [7:0] ext_val_def, ext_val_neg;

    wire  [7:0] pin_def, pin_pu, pin_reg, pin_neg, pin_comb, pin_none;
    logic [7:0] din_def, din_pu, din_reg, din_neg, din_comb, din_none;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign pin_def = ext_en_def ? ext_val_def : 8'hzz;
    assign pin_neg = ext_en_neg ? ext_val_neg : 8'hzz;

    bidir_io_cell #(.WIDTH(8), .PIN_TYPE(6'b101001), .PULLUP(1'b0)) u_def (
        .clk(clk), .rst(rst), .package_pin(pin_def), .output_enable(oe), .d_out_0(dout), .d_in_0(din_def));
    bidir_io_cell #(.WIDTH(8), .PIN_TYPE(6'b101001), .PULLUP(1'b1)) u_pu (
        .clk(clk), .rst(rst), .package_pin(pin_pu), .output_enable(oe), .d_out_0(dout), .d_in_0(din_pu));
    bidir_io_cell #(.WIDTH(8), .PIN_TYPE(6'b110100), .PULLUP(1'b0)) u_reg (
        .clk(clk), .rst(rst), .package_pin(pin_reg), .output_enable(oe), .d_out_0(dout), .d_in_0(din_reg));
    bidir_io_cell #(.WIDTH(8), .PIN_TYPE(6'b101010), .PULLUP(1'b0)) u_neg (
        .clk(clk), .rst(rst), .package_pin(pin_neg), .output_enable(oe), .d_out_0(dout), .d_in_0(din_neg));
    bidir_io_cell #(.WIDTH(8), .PIN_TYPE(6'b011001), .PULLUP(1'b0)) u_comb (
        .clk(clk), .rst(rst), .package_pin(pin_comb), .output_enable(oe), .d_out_0(dout), .d_in_0(din_comb));
    bidir_io_cell #(.WIDTH(8), .PIN_TYPE(6'b000001), .PULLUP(1'b0)) u_none (
        .clk(clk), .rst(rst), .package_pin(pin_none), .output_enable(oe), .d_out_0(dout), .d_in_0(din_none));

    typedef struct {
        logic       oe;
        logic [7:0] dout;
        logic       ext_en;
        logic [7:0] ext_val;
        logic       def_rel;   // default pad expected undriven by anyone
        logic [7:0] def_exp;
        logic [7:0] pu_exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // An undriven net reads as z in four-state simulators and 0 in two-state ones.
    task automatic check_rel(input string name, input logic [7:0] act);
        n_cmp++;
        if (!(act === 8'hzz || act === 8'h00)) begin
            n_fail++;
            $display("FAIL %s: got %h, want released (zz) at %0t", name, act, $time);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'hA5, 8'hA5};
        vecs[1] = '{1'b0, 8'hA5, 1'b1, 8'h3C, 1'b0, 8'h3C, 8'hFF};
        vecs[2] = '{1'b0, 8'h12, 1'b0, 8'h00, 1'b1, 8'h00, 8'hFF};
        vecs[3] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hFF, 8'hFF};
        vecs[5] = '{1'b0, 8'h12, 1'b1, 8'h81, 1'b0, 8'h81, 8'hFF};
        vecs[6] = '{1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h5A, 8'h5A};

        rst = 1'b1;
        oe = 1'b0;
        dout = 8'h00;
        ext_en_def = 1'b0;
        ext_val_def = 8'h00;
        ext_en_neg = 1'b0;
        ext_val_neg = 8'h00;

        #7;
        check_rel("reset reg pin", pin_reg);
        check("reset reg din", din_reg, 8'h00);
        check("reset neg din", din_neg, 8'h00);

        // Combinational modes, applied while rst is held to show it has no effect on them.
        for (int i = 0; i < 7; i++) begin
            oe = vecs[i].oe;
            dout = vecs[i].dout;
            ext_en_def = vecs[i].ext_en;
            ext_val_def = vecs[i].ext_val;
            #1;
            if (vecs[i].def_rel) begin
                check_rel($sformatf("v%0d def pin", i), pin_def);
                check_rel($sformatf("v%0d def din", i), din_def);
            end else begin
                check($sformatf("v%0d def pin", i), pin_def, vecs[i].def_exp);
                check($sformatf("v%0d def din", i), din_def, vecs[i].def_exp);
            end
            check($sformatf("v%0d pu pin", i), pin_pu, vecs[i].pu_exp);
            check($sformatf("v%0d pu din", i), din_pu, vecs[i].pu_exp);
            check($sformatf("v%0d comb pin", i), pin_comb, vecs[i].dout);
            check($sformatf("v%0d comb din", i), din_comb, vecs[i].dout);
            check_rel($sformatf("v%0d none pin", i), pin_none);
            check_rel($sformatf("v%0d none din", i), din_none);
        end
        ext_en_def = 1'b0;

        // Registered output with registered enable, posedge-registered input.
        @(negedge clk);
        rst = 1'b0;
        oe = 1'b1;
        dout = 8'h5A;
        #1;
        check_rel("reg pin before edge", pin_reg);
        @(posedge clk); #1;
        check("reg pin after edge", pin_reg, 8'h5A);
        check_rel("reg din first edge", din_reg);
        @(posedge clk); #1;
        check("reg din second edge", din_reg, 8'h5A);

        // Asynchronous reset mid-operation.
        dout = 8'hFF;
        @(posedge clk); #1;
        check("reg pin ff", pin_reg, 8'hFF);
        @(posedge clk); #1;
        check("reg din ff", din_reg, 8'hFF);
        #2;
        rst = 1'b1;
        #1;
        check_rel("reg pin async rst", pin_reg);
        check("reg din async rst", din_reg, 8'h00);
        @(posedge clk); #1;
        check_rel("reg pin rst over edge", pin_reg);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_rel("reg pin after rst release", pin_reg);
        @(posedge clk); #1;
        check("reg pin redrive", pin_reg, 8'hFF);

        // Dropping the enable only takes effect at the next posedge.
        oe = 1'b0;
        #1;
        check("reg pin oe drop pre-edge", pin_reg, 8'hFF);
        @(posedge clk); #1;
        check_rel("reg pin oe drop post-edge", pin_reg);

        // Negedge-registered input.
        @(negedge clk); #1;
        ext_en_neg = 1'b1;
        ext_val_neg = 8'h00;
        @(negedge clk); #1;
        check("neg din preload", din_neg, 8'h00);
        ext_val_neg = 8'h77;
        @(posedge clk); #1;
        check("neg din at posedge", din_neg, 8'h00);
        @(negedge clk); #1;
        check("neg din at negedge", din_neg, 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bidir_io_cell.md
Name: bidir_io_cell

Overview:
Parameterised bidirectional pad cell, WIDTH bits wide, built as an SB_IO-style primitive model.
Drives a tri-state package pin from core data under an output enable, and returns the pin value to the core.
Output and input paths are each selectable as combinational or registered.
Used by the SDRAM controller for the 8-bit DQ bus: tri-state combinational output, combinational input.

Parameters:
WIDTH, 8, number of pad bits (independent identical bit cells).
PIN_TYPE, 6'b101001, [5:2] output mode, [1:0] input mode (encodings in Behaviour).
PULLUP, 1'b0, 1 = weak pull-up on the pin when undriven.

Ports:
clk  input  1  single clock for all registered modes.
rst  input  1  asynchronous, active-high reset.
package_pin  inout  WIDTH  external pad.
output_enable  input  1  drive-enable, common to all bits, used in tri-state modes.
d_out_0  input  WIDTH  data to drive onto the pad.
d_in_0  output  WIDTH  data sampled from the pad.

Behaviour:
- Output modes, PIN_TYPE[5:2]:
  - 0000: never drive; pad is Z.
  - 0110: always drive d_out_0, combinational.
  - 0101: always drive, data registered on posedge clk.
  - 1010: drive d_out_0 combinationally when output_enable=1, else Z.
  - 1101: data and enable both registered on posedge clk; drive registered data when registered enable=1, else Z.
  - Any other code: behave as 0000 and issue a simulation $display warning at time 0.
- Input modes, PIN_TYPE[1:0]:
  - 01: d_in_0 = pad value, combinational, 0 latency.
  - 00: d_in_0 registered on posedge clk, 1-cycle latency.
  - 10: d_in_0 registered on negedge clk, half-cycle latency. Used for capturing SDRAM data at the DRAM clock edge.
  - 11: behave as 01.
- Pad value seen by the input path:
  - While the cell is driving, it is the driven value (loop-back).
  - While undriven, it is the external value.
  - If PULLUP=1 and a bit is Z, that bit reads 1.
  - If PULLUP=0 and a bit is Z, the Z propagates.
- Reset (rst=1, asynchronous):
  - All output-data registers, the enable register and the input registers clear to 0.
  - Consequence: in mode 1101 the pad goes Z immediately on rst assertion, mid-operation included. In mode 0101 the pad drives 0.
  - Combinational paths are unaffected by rst.
- Registered-mode timing:
  - Values present at posedge N appear on the pad after posedge N.
  - Enable and data registers update in the same edge, so no single-cycle glitch of stale data under a new enable.
- Simultaneous events: rst dominates any clock edge. output_enable toggling in the same cycle as d_out_0 changes in mode 1010 takes effect combinationally with no ordering requirement.
- Bits are fully independent. There is no cross-bit logic apart from the shared output_enable.

Decomposition:
- Shared package io_cell_pkg: localparams for the output modes (OUT_NONE=4'b0000, OUT_COMB=4'b0110, OUT_REG=4'b0101, OUT_TRI_COMB=4'b1010, OUT_TRI_REG=4'b1101) and input modes (IN_REG_POS=2'b00, IN_COMB=2'b01, IN_REG_NEG=2'b10), plus a PIN_TYPE builder function.
- One sub-module io_bit_cell (single bit, same parameters minus WIDTH), instantiated WIDTH times by a generate loop in bidir_io_cell.

Test Plan:
1. Default PIN_TYPE, output_enable=1, d_out_0=8'hA5 -> package_pin=8'hA5 and d_in_0=8'hA5 in the same delta. Then output_enable=0, bench drives 8'h3C -> package_pin=8'h3C, d_in_0=8'h3C, cell not driving.
2. Default PIN_TYPE, output_enable=0, bench releases the pin -> d_in_0=8'hZZ. Repeat with PULLUP=1 -> d_in_0=8'hFF.
3. PIN_TYPE=6'b110100, output_enable=1, d_out_0=8'h5A set before posedge 1 -> pin Z before that edge, 8'h5A after it. d_in_0 = 8'h5A one posedge later.
4. PIN_TYPE=6'b110100 driving 8'hFF, assert rst between edges -> pin goes Z immediately and d_in_0 clears to 8'h00. Deassert rst, next posedge with output_enable=1 -> drives again.
5. PIN_TYPE=6'b101010, bench drives 8'h77 on the pin -> d_in_0 updates to 8'h77 only at negedge clk, unchanged at the preceding posedge.
6. PIN_TYPE=6'b011001, output_enable=0, d_out_0=8'h12 -> pin driven 8'h12 regardless of output_enable. PIN_TYPE=6'b000001 -> pin always Z.
